weight_arbiter: RTL and testbench
=================================

WEIGHT_ARBITER -- requirements
Module: weight_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 6: number of layer requesters (upsample plus conv1..conv5).
REQ-002 Parameter ADDR_WIDTH, default 18: weight memory address width.
REQ-003 Parameter DATA_WIDTH, default 16: weight word width.
REQ-004 Parameter LEN_WIDTH, default 12: burst length field width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  NUM_REQ  per-requester burst request, level.
REQ-008 req_base_addr  input  NUM_REQ*ADDR_WIDTH  per-requester first weight address; slice i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_len  input  NUM_REQ*LEN_WIDTH  per-requester word count; slice i at [i*LEN_WIDTH +: LEN_WIDTH].
REQ-010 grant  output  NUM_REQ  one-hot owner of the memory port, registered.
REQ-011 mem_rd_en  output  1  weight memory read strobe, registered.
REQ-012 mem_addr  output  ADDR_WIDTH  weight memory read address, registered.
REQ-013 mem_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 wdata  output  DATA_WIDTH  mem_data passed through combinationally.
REQ-015 wvalid  output  NUM_REQ  one-hot: wdata belongs to requester i this cycle, registered.
REQ-016 burst_done  output  NUM_REQ  one-cycle pulse to the owning requester when its burst completes.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, DRAIN.
REQ-019 IDLE: if any req bit is set, select the winner by round-robin starting at index (last_winner+1) mod NUM_REQ; register grant=onehot(winner), latch base and len of the winner, set last_winner=winner.
REQ-020 Winner latched with len>0: next state ISSUE; len==0: next state DRAIN with no reads.
REQ-021 ISSUE: mem_rd_en=1 and mem_addr=base+k on the k-th ISSUE cycle (k=0..len-1), exactly len consecutive cycles, then DRAIN.
REQ-022 Address arithmetic is modulo 2^ADDR_WIDTH (wrap past all-ones to 0).
REQ-023 wvalid[i] is high in the cycle after each mem_rd_en issued while grant[i]=1; exactly len wvalid pulses per burst.
REQ-024 DRAIN (one cycle): burst_done[winner]=1 is registered, arriving in the cycle after DRAIN; grant clears to 0 at that same edge, and the next state is IDLE.
REQ-025 Timing: req sampled at cycle 0 -> grant at 1 -> reads at 1..len -> last wvalid at len+1 -> burst_done pulse at len+2 with grant=0 and state IDLE; next grant no earlier than len+3.
REQ-026 req, req_base_addr and req_len changes after the latch cycle are ignored until the burst completes; deasserting req mid-burst does not abort it.
REQ-027 A requester still holding req after burst_done is eligible again, but loses to any other pending requester (round-robin fairness).
REQ-028 At most one grant bit is high at any time; at most one wvalid bit is high at any time.
REQ-029 req_len is interpreted as unsigned; the maximum burst is 2^LEN_WIDTH-1 words.

Reset
REQ-030 rst_n low forces, asynchronously, state=IDLE, grant=0, mem_rd_en=0, mem_addr=0, wvalid=0, burst_done=0, busy=0, and last_winner=NUM_REQ-1 (so index 0 wins first).
REQ-031 Reset mid-burst abandons the burst: no further wvalid and no burst_done are generated for it.

Verification
REQ-032 Single burst: req[0]=1, base=0, len=4 -> grant=000001 at cycle 1; mem_addr 0,1,2,3 at cycles 1-4; wvalid[0] at cycles 2-5; burst_done[0] pulse at cycle 6 with grant=0.
REQ-033 Contention: req=6'b100101 held, all len=2 -> grant order 0, 2, 5, 0; no overlap; each wvalid count is 2.
REQ-034 Zero length: req[3]=1, len=0 -> grant[3] at cycle 1; burst_done[3] at cycle 2 with grant=0; mem_rd_en and wvalid never asserted.
REQ-035 Wrap: base=18'h3FFFE, len=4 -> mem_addr 3FFFE, 3FFFF, 00000, 00001.
REQ-036 Reset mid-burst: len=10, rst_n low at cycle 5 -> all outputs are 0 immediately; after release req[0] is regranted from base and burst_done occurs only once, for the new burst.
REQ-037 Req drop: req[1] deasserted at cycle 2 of a len=3 burst -> all 3 reads, 3 wvalid pulses and burst_done[1] still occur.

Source files
------------

// File: rtl/weight_arbiter.sv
// Round-robin arbiter granting the shared weight memory read port to one layer
// requester at a time and streaming that requester's burst back to it.
module weight_arbiter #(
  parameter int NUM_REQ    = 6,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [NUM_REQ-1:0]            wvalid,
  output logic [NUM_REQ-1:0]            burst_done,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_last;
  logic [IDX_W-1:0]      w_win;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_any;
  int                    w_rr_pos;
  logic [ADDR_WIDTH-1:0] w_win_base;
  logic [LEN_WIDTH-1:0]  w_win_len;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_wvalid;
  logic [NUM_REQ-1:0]    r_done;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_addr;

  // Scan from the farthest offset down so the nearest pending index after
  // the last winner is the one left standing.
  always_comb begin
    w_any    = 1'b0;
    w_win    = r_last;
    w_idx    = '0;
    w_rr_pos = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_rr_pos = int'(r_last) + off;
      if (w_rr_pos >= NUM_REQ) w_rr_pos = w_rr_pos - NUM_REQ;
      w_idx = IDX_W'(w_rr_pos);
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_win_base = req_base_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_win_len  = req_len[w_win*LEN_WIDTH +: LEN_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = (w_win_len != '0) ? ISSUE : DRAIN;
      ISSUE:   if (r_remain == LEN_WIDTH'(1)) w_next = DRAIN;
      DRAIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The first read address is loaded at the latch edge so reads start in
  // the same cycle the grant appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_remain <= '0;
      r_grant  <= '0;
      r_wvalid <= '0;
      r_done   <= '0;
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_done   <= '0;
      r_wvalid <= r_rd_en ? r_grant : '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant  <= NUM_REQ'(1) << w_win;
            r_last   <= w_win;
            r_remain <= w_win_len;
            if (w_win_len != '0) begin
              r_rd_en <= 1'b1;
              r_addr  <= w_win_base;
            end
          end
        end
        ISSUE: begin
          r_remain <= r_remain - LEN_WIDTH'(1);
          if (r_remain == LEN_WIDTH'(1)) begin
            r_rd_en <= 1'b0;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          r_done  <= r_grant;
          r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant      = r_grant;
  assign mem_rd_en  = r_rd_en;
  assign mem_addr   = r_addr;
  assign wvalid     = r_wvalid;
  assign burst_done = r_done;
  assign wdata      = mem_data;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_weight_arbiter.sv
// Bench for weight_arbiter: directed scenarios plus randomized chained bursts,
// checked against a burst-timeline reference model and a synthetic memory.
module tb_weight_arbiter;
  localparam int N  = 6;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int LW = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_base_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]    grant;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data = '0;
  logic [DW-1:0]   wdata;
  logic [N-1:0]    wvalid;
  logic [N-1:0]    burst_done;
  logic            busy;

  int ncmp = 0;
  int nerr = 0;
  int last_w = N - 1;

  weight_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_base_addr(req_base_addr),
    .req_len(req_len), .grant(grant), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .wdata(wdata), .wvalid(wvalid), .burst_done(burst_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return (a[15:0] * 16'd7) ^ 16'h3C5A ^ {14'd0, a[17:16]};
  endfunction

  // Synthetic memory: data for the address presented at an edge appears one cycle later.
  always @(posedge clk) mem_data <= memf(mem_addr);

  // Round-robin reference: pending index with the smallest forward distance past last_w.
  function automatic int pick(input logic [N-1:0] v);
    int best;
    int bd;
    int d;
    best = -1;
    bd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - last_w - 1 + 2 * N) % N;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [AW-1:0] b, input int l);
    req_base_addr[i*AW +: AW] = b;
    req_len[i*LW +: LW] = LW'(l);
  endtask

  task automatic scramble_all(input int maxlen);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) set_ch(i, AW'(18'h3FFFA + $urandom_range(0, 5)), int'($urandom_range(0, maxlen)));
      else set_ch(i, AW'($urandom), int'($urandom_range(0, maxlen)));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wvalid"}, 32'(wvalid), 0);
    chk({tag, "_done"}, 32'(burst_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    last_w = N - 1;
  endtask

  // Called in an IDLE cycle (cycle 0); checks cycles 1..len+2 of the predicted burst.
  task automatic run_burst(input int drop_all_c, input int drop_own_c, input bit scramble);
    int w;
    int len;
    logic [AW-1:0] base;
    logic [AW-1:0] ea;
    logic [N-1:0] oh;
    w = pick(req);
    if (w < 0) return;
    last_w = w;
    base = req_base_addr[w*AW +: AW];
    len = int'(req_len[w*LW +: LW]);
    oh = N'(1) << w;
    for (int c = 1; c <= len + 2; c++) begin
      tick();
      chk("grant", 32'(grant), (c <= len + 1) ? 32'(oh) : 32'd0);
      chk("busy", 32'(busy), (c <= len + 1) ? 32'd1 : 32'd0);
      chk("rd_en", 32'(mem_rd_en), (c <= len) ? 32'd1 : 32'd0);
      if (c <= len) begin
        ea = base + AW'(c - 1);
        chk("addr", 32'(mem_addr), 32'(ea));
      end
      chk("wvalid", 32'(wvalid), (c >= 2 && c <= len + 1) ? 32'(oh) : 32'd0);
      if (c >= 2 && c <= len + 1) begin
        ea = base + AW'(c - 2);
        chk("wdata", 32'(wdata), 32'(memf(ea)));
      end
      chk("burst_done", 32'(burst_done), (c == len + 2) ? 32'(oh) : 32'd0);
      if (c == drop_all_c) req = '0;
      if (c == drop_own_c) req[w] = 1'b0;
      if (scramble && c == 1) begin
        scramble_all(6);
        req = N'($urandom);
      end
    end
  endtask

  initial begin
    do_reset();

    // Single burst from index 0
    req = 6'b000001;
    set_ch(0, 18'h00000, 4);
    run_burst(1, 0, 1'b0);

    // Contention with held requests: expected order 0, 2, 5, 0
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, AW'(i * 16), 2);
    req = 6'b100101;
    run_burst(0, 0, 1'b0);
    run_burst(0, 0, 1'b0);
    run_burst(0, 0, 1'b0);
    run_burst(1, 0, 1'b0);

    // Zero-length burst
    req = 6'b001000;
    set_ch(3, 18'h00005, 0);
    run_burst(1, 0, 1'b0);

    // Address wrap
    req = 6'b010000;
    set_ch(4, 18'h3FFFE, 4);
    run_burst(1, 0, 1'b0);

    // Requester drops req mid-burst
    req = 6'b000010;
    set_ch(1, 18'h00100, 3);
    run_burst(0, 2, 1'b0);

    // Reset in the middle of a long burst
    req = 6'b000001;
    set_ch(0, 18'h00200, 10);
    for (int c = 1; c <= 5; c++) tick();
    chk("mid_grant_before", 32'(grant), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    chk("rst_hold_wvalid", 32'(wvalid), 0);
    chk("rst_hold_done", 32'(burst_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_w = N - 1;
    run_burst(1, 0, 1'b0);

    // Randomized chained bursts with inputs scrambled after each latch
    scramble_all(6);
    for (int it = 0; it < 30; it++) begin
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      run_burst(0, 0, 1'b1);
    end
    req = '0;
    tick();
    tick();
    chk("end_idle_busy", 32'(busy), 0);
    chk("end_idle_grant", 32'(grant), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
